// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts a request, waits a programmable
// latency, then performs a word read or byte-masked write and holds the response.
module mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [3:0]         cnt_r;
  logic               wen_r;
  logic [IDX_W-1:0]   idx_r;
  logic [31:0]        wdata_r;
  logic [3:0]         wmask_r;
  logic               err_r;
  logic               rsp_valid_r;
  logic               rsp_err_r;
  logic [31:0]        rsp_rdata_r;
  logic [31:0]        mem [DEPTH_WORDS];

  logic [31:0]        offset_s;
  logic               out_of_range_s;
  logic               accept_s;
  logic               access_s;
  logic               mem_we_s;
  logic               acc_wen_s;
  logic [IDX_W-1:0]   acc_idx_s;
  logic [31:0]        acc_wdata_s;
  logic [3:0]         acc_wmask_s;
  logic               acc_err_s;

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  // Next-state decode, address range check and access-source selection.
  always_comb begin
    offset_s       = req_addr - ADDR_BASE;
    out_of_range_s = !(offset_s < SPAN);
    accept_s       = (state_r == IDLE) && req_valid;
    next_state_s   = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          next_state_s = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase

    access_s = (next_state_s == RESP) && (state_r != RESP);

    // With a one-cycle latency the access happens on the accept edge itself,
    // so the live request inputs stand in for the not-yet-captured copy.
    if (state_r == IDLE) begin
      acc_wen_s   = req_wen;
      acc_idx_s   = offset_s[IDX_W+1:2];
      acc_wdata_s = req_wdata;
      acc_wmask_s = req_wmask;
      acc_err_s   = out_of_range_s;
    end else begin
      acc_wen_s   = wen_r;
      acc_idx_s   = idx_r;
      acc_wdata_s = wdata_r;
      acc_wmask_s = wmask_r;
      acc_err_s   = err_r;
    end

    mem_we_s = access_s && acc_wen_s && !acc_err_s && rst;
  end

  // State, latency counter, captured request and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      wen_r       <= 1'b0;
      idx_r       <= '0;
      wdata_r     <= 32'd0;
      wmask_r     <= 4'd0;
      err_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'd0;
    end else begin
      state_r <= next_state_s;
      if (accept_s) begin
        wen_r   <= req_wen;
        idx_r   <= offset_s[IDX_W+1:2];
        wdata_r <= req_wdata;
        wmask_r <= req_wmask;
        err_r   <= out_of_range_s;
        cnt_r   <= CNT_INIT;
      end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (access_s) begin
        rsp_valid_r <= 1'b1;
        rsp_err_r   <= acc_err_s;
        rsp_rdata_r <= (!acc_err_s && !acc_wen_s) ? mem[acc_idx_s] : 32'd0;
      end else if ((state_r == RESP) && rsp_ready) begin
        rsp_valid_r <= 1'b0;
        rsp_err_r   <= 1'b0;
      end
    end
  end

  // Byte-lane writes into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wmask_s[i]) begin
          mem[acc_idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder with hand-written sequences
// for backpressure and reset during an outstanding write.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_responder #(
    .ADDR_BASE  (32'h8000_0000),
    .DEPTH_WORDS(1024),
    .LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wen  (req_wen),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wmask(req_wmask),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v, input string tag);
    int k;
    int lat;
    req_valid = 1'b1;
    req_wen   = v.wen;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_wmask = v.wmask;
    k = 0;
    while (!req_ready && k < 20) begin
      tick();
      k++;
    end
    chk({tag, " ready_timeout"}, 32'(k < 20), 32'd1);
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(LAT));
    chk({tag, " rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, " err"}, 32'(rsp_err), 32'(v.exp_err));
    chk({tag, " req_ready_in_resp"}, 32'(req_ready), 32'd0);
    for (int s = 0; s < v.stall; s++) begin
      tick();
      chk({tag, " stall_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " stall_rdata"}, rsp_rdata, v.exp_rdata);
      chk({tag, " stall_err"}, 32'(rsp_err), 32'(v.exp_err));
      chk({tag, " stall_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, " post_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " post_err"}, 32'(rsp_err), 32'd0);
    chk({tag, " post_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    vec_t rd;
    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 5, 32'hDE22_BE44, 1'b0};
    vecs[4]  = '{1'b1, 32'h8000_0000, 32'hA5A5_A5A5, 4'hF, 0, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 4'h0, 0, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 2, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0000_0000, 4'h0, 0, 32'hA5A5_A5A5, 1'b0};
    vecs[8]  = '{1'b1, 32'h8000_0FFC, 32'h0BAD_F00D, 4'hF, 0, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 32'h8000_0FFE, 32'h0000_0000, 4'h0, 0, 32'h0BAD_F00D, 1'b0};
    vecs[10] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 0, 32'hDE22_BE44, 1'b0};
    vecs[12] = '{1'b1, 32'h8000_0020, 32'h1357_9BDF, 4'hF, 0, 32'h0000_0000, 1'b0};

    rst       = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_wmask = 4'd0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);

    for (int i = 0; i < 13; i++) begin
      do_req(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset lands while the write is still waiting for its access edge.
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0020;
    req_wdata = 32'hCAFE_F00D;
    req_wmask = 4'hF;
    tick();
    req_valid = 1'b0;
    chk("abort in_wait req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort reset req_ready", 32'(req_ready), 32'd1);
    chk("abort reset rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort no_response", 32'(rsp_valid), 32'd0);
      chk("abort idle", 32'(req_ready), 32'd1);
    end
    rd = '{1'b0, 32'h8000_0020, 32'h0000_0000, 4'h0, 0, 32'h1357_9BDF, 1'b0};
    do_req(rd, "abort readback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
